reg_drain: RTL and testbench

Readout engine for a bank of PE-side `register` instances. On a snapshot request it captures all `NUM_REGS` signed register outputs in one cycle into a shadow buffer, then streams them out one element per cycle over a valid/ready interface, in index order, tagged with index and last. It sits between the PE array's partial-sum/output registers and the output buffer/GLB write path. Capturing into a shadow buffer frees the source registers to be reloaded through `set_reg` while the drain is in progress.

---
 rtl/reg_drain.sv | 153 +++++++++++++++
 tb/tb_reg_drain.sv | 335 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/reg_drain.sv
// ---------------------------------------------------------------------------
// reg_drain
//
// Readout engine for a bank of PE-side registers. A snapshot request copies
// every register value into a shadow buffer in a single cycle, after which the
// buffer is streamed out one element per cycle over a valid/ready interface,
// in index order. Because the stream comes from the shadow copy, the source
// registers may be reloaded while the drain is still running.
//
// Parameters
//   DATA_WIDTH : width of each signed register value
//   NUM_REGS   : number of registers in the bank (>= 1)
//   IDX_WIDTH  : derived index width, max(1, clog2(NUM_REGS))
//
// Ports
//   clk        : clock, rising edge
//   rst        : synchronous active-high reset
//   snap       : capture request, sampled every cycle
//   reg_bus    : flattened register outputs, register i at [i*DW +: DW]
//   busy       : high while streaming (identical to out_valid)
//   out_valid  : output element valid
//   out_ready  : consumer accepts the element
//   out_data   : signed element value
//   out_idx    : register index of out_data
//   out_last   : element is the final one of the snapshot
//   done       : one-cycle pulse after the final handshake of a snapshot
//   snap_drop  : one-cycle pulse after a snap request was ignored
// ---------------------------------------------------------------------------
module reg_drain #(
    parameter  int DATA_WIDTH = 16,
    parameter  int NUM_REGS   = 8,
    localparam int IDX_WIDTH  = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             snap,
    input  logic [NUM_REGS*DATA_WIDTH-1:0]   reg_bus,
    output logic                             busy,
    output logic                             out_valid,
    input  logic                             out_ready,
    output logic signed [DATA_WIDTH-1:0]     out_data,
    output logic [IDX_WIDTH-1:0]             out_idx,
    output logic                             out_last,
    output logic                             done,
    output logic                             snap_drop
);

    typedef enum logic {
        ST_IDLE   = 1'b0,
        ST_STREAM = 1'b1
    } state_t;

    localparam logic [IDX_WIDTH-1:0] IDX_LAST = IDX_WIDTH'(NUM_REGS - 1);

    // Unpacked view of the incoming register bus.
    logic signed [DATA_WIDTH-1:0] reg_slice [NUM_REGS];

    generate
        for (genvar gi = 0; gi < NUM_REGS; gi++) begin : g_slice
            assign reg_slice[gi] = reg_bus[gi*DATA_WIDTH +: DATA_WIDTH];
        end
    endgenerate

    state_t                       state_q,  state_d;
    logic [IDX_WIDTH-1:0]         idx_q,    idx_d;
    logic signed [DATA_WIDTH-1:0] data_q,   data_d;
    logic signed [DATA_WIDTH-1:0] shadow_q [NUM_REGS];
    logic signed [DATA_WIDTH-1:0] shadow_d [NUM_REGS];
    logic                         done_q,   done_d;
    logic                         drop_q,   drop_d;

    logic                         handshake;
    logic                         final_hs;
    logic                         capture;
    logic [IDX_WIDTH-1:0]         idx_inc;

    // out_data is kept as its own register and preloaded with the next
    // element on every handshake, so no output depends on out_ready or snap
    // through combinational logic.
    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        data_d    = data_q;
        shadow_d  = shadow_q;
        done_d    = 1'b0;
        drop_d    = 1'b0;

        handshake = (state_q == ST_STREAM) && out_ready;
        final_hs  = handshake && (idx_q == IDX_LAST);
        idx_inc   = idx_q + 1'b1;
        // A snap coinciding with the final handshake is honoured, giving
        // back-to-back snapshots without an idle bubble.
        capture   = snap && ((state_q == ST_IDLE) || final_hs);

        case (state_q)
            ST_IDLE: begin
                if (capture) begin
                    state_d = ST_STREAM;
                end
            end
            ST_STREAM: begin
                done_d = final_hs;
                drop_d = snap && !final_hs;
                if (final_hs && !capture) begin
                    state_d = ST_IDLE;
                    idx_d   = '0;
                    data_d  = '0;
                end else if (handshake && !final_hs) begin
                    idx_d  = idx_inc;
                    data_d = shadow_q[idx_inc];
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        if (capture) begin
            shadow_d = reg_slice;
            idx_d    = '0;
            data_d   = reg_slice[0];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            idx_q   <= '0;
            data_q  <= '0;
            done_q  <= 1'b0;
            drop_q  <= 1'b0;
            for (int i = 0; i < NUM_REGS; i++) begin
                shadow_q[i] <= '0;
            end
        end else begin
            state_q  <= state_d;
            idx_q    <= idx_d;
            data_q   <= data_d;
            done_q   <= done_d;
            drop_q   <= drop_d;
            shadow_q <= shadow_d;
        end
    end

    assign busy      = (state_q == ST_STREAM);
    assign out_valid = (state_q == ST_STREAM);
    assign out_data  = data_q;
    assign out_idx   = idx_q;
    assign out_last  = (state_q == ST_STREAM) && (idx_q == IDX_LAST);
    assign done      = done_q;
    assign snap_drop = drop_q;

endmodule

// File: tb/tb_reg_drain.sv
module tb_reg_drain;

    localparam int DW = 16;
    localparam int NR = 4;
    localparam int IW = 2;

    logic               clk;
    logic               rst;
    logic               snap;
    logic [NR*DW-1:0]   reg_bus;
    logic               busy;
    logic               out_valid;
    logic               out_ready;
    logic signed [DW-1:0] out_data;
    logic [IW-1:0]      out_idx;
    logic               out_last;
    logic               done;
    logic               snap_drop;

    reg_drain #(
        .DATA_WIDTH (DW),
        .NUM_REGS   (NR)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .snap      (snap),
        .reg_bus   (reg_bus),
        .busy      (busy),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_idx   (out_idx),
        .out_last  (out_last),
        .done      (done),
        .snap_drop (snap_drop)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [DW-1:0] data;
        logic [IW-1:0] idx;
        logic          last;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_pass   = 0;
    int   done_cnt = 0;
    int   drop_cnt = 0;

    localparam logic [NR*DW-1:0] BUS_A = {16'hFFFF, 16'h7FFF, 16'h8000, 16'h0003};
    localparam logic [NR*DW-1:0] BUS_B = {16'h0044, 16'h0033, 16'h0022, 16'h0011};
    localparam logic [NR*DW-1:0] BUS_X = {16'h1234, 16'h1234, 16'h1234, 16'h1234};
    localparam logic [NR*DW-1:0] BUS_C = {16'hA5A5, 16'h0F0F, 16'h8001, 16'h5A5A};

    // Scoreboard: every accepted element is compared against the oldest
    // expected entry.
    always @(negedge clk) begin
        if (!rst && out_valid && out_ready) begin
            exp_t got;
            exp_t want;
            got = {out_data, out_idx, out_last};
            n_checks++;
            if (exp_q.size() == 0) begin
                $display("FAIL stream_unexpected: got data=%h idx=%0d last=%0d, required no element",
                         out_data, out_idx, out_last);
            end else begin
                want = exp_q.pop_front();
                if (got !== want) begin
                    $display("FAIL stream_elem: got data=%h idx=%0d last=%0d, required data=%h idx=%0d last=%0d",
                             got.data, got.idx, got.last, want.data, want.idx, want.last);
                end else begin
                    n_pass++;
                    $display("xfer data=%h idx=%0d last=%0d", got.data, got.idx, got.last);
                end
            end
        end
        if (!rst && done)      done_cnt++;
        if (!rst && snap_drop) drop_cnt++;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_snapshot(input logic [NR*DW-1:0] bus);
        for (int i = 0; i < NR; i++) begin
            exp_t e;
            e.data = bus[i*DW +: DW];
            e.idx  = IW'(i);
            e.last = (i == NR - 1);
            exp_q.push_back(e);
        end
    endtask

    // Runs until done is observed, bounded.
    task automatic wait_done(input string name);
        bit seen = 0;
        for (int c = 0; c < 20 && !seen; c++) begin
            @(negedge clk);
            if (done) seen = 1;
            else tick();
        end
        n_checks++;
        if (!seen) $display("FAIL %s_timeout: got no done within 20 cycles, required done", name);
        else n_pass++;
        tick();
    endtask

    task automatic test_reset();
        rst = 1'b1; snap = 1'b1; out_ready = 1'b1; reg_bus = BUS_A;
        for (int c = 0; c < 2; c++) begin
            tick();
            @(negedge clk);
            n_checks++;
            if ({busy, out_valid, out_last, done, snap_drop, out_data, out_idx} !== '0)
                $display("FAIL reset_during: got busy=%0d valid=%0d last=%0d done=%0d drop=%0d data=%h idx=%0d, required all 0",
                         busy, out_valid, out_last, done, snap_drop, out_data, out_idx);
            else n_pass++;
        end
        tick();
        rst = 1'b0; snap = 1'b0;
        for (int c = 0; c < 3; c++) begin
            tick();
            @(negedge clk);
            n_checks++;
            if ({busy, out_valid, out_last, done, snap_drop, out_data, out_idx} !== '0)
                $display("FAIL reset_after: got busy=%0d valid=%0d last=%0d done=%0d drop=%0d data=%h idx=%0d, required all 0",
                         busy, out_valid, out_last, done, snap_drop, out_data, out_idx);
            else n_pass++;
        end
        tick();
    endtask

    task automatic test_basic();
        int d0 = done_cnt;
        reg_bus = BUS_A; out_ready = 1'b1; snap = 1'b1;
        push_snapshot(BUS_A);
        tick();
        snap = 1'b0;
        for (int k = 0; k < NR; k++) begin
            @(negedge clk);
            n_checks++;
            if (out_valid !== 1'b1 || busy !== 1'b1 || out_idx !== IW'(k) || done !== 1'b0)
                $display("FAIL basic_cycle%0d: got valid=%0d busy=%0d idx=%0d done=%0d, required valid=1 busy=1 idx=%0d done=0",
                         k, out_valid, busy, out_idx, done, k);
            else n_pass++;
            tick();
        end
        @(negedge clk);
        n_checks++;
        if (done !== 1'b1 || out_valid !== 1'b0 || busy !== 1'b0)
            $display("FAIL basic_end: got done=%0d valid=%0d busy=%0d, required done=1 valid=0 busy=0",
                     done, out_valid, busy);
        else n_pass++;
        tick();
        @(negedge clk);
        n_checks++;
        if (done !== 1'b0 || done_cnt != d0 + 1 || exp_q.size() != 0)
            $display("FAIL basic_done_once: got done=%0d pulses=%0d left=%0d, required done=0 pulses=1 left=0",
                     done, done_cnt - d0, exp_q.size());
        else n_pass++;
        tick();
    endtask

    task automatic test_backpressure();
        reg_bus = BUS_A; out_ready = 1'b1; snap = 1'b1;
        push_snapshot(BUS_A);
        tick();
        snap = 1'b0;
        tick();                       // idx 0 accepted, now showing idx 1
        out_ready = 1'b0;
        reg_bus   = BUS_X;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            n_checks++;
            if (out_valid !== 1'b1 || out_idx !== 2'd1 || out_data !== 16'sh8000 || out_last !== 1'b0)
                $display("FAIL stall_hold%0d: got valid=%0d idx=%0d data=%h last=%0d, required valid=1 idx=1 data=8000 last=0",
                         c, out_valid, out_idx, out_data, out_last);
            else n_pass++;
            tick();
        end
        out_ready = 1'b1;
        wait_done("backpressure");
        n_checks++;
        if (exp_q.size() != 0)
            $display("FAIL backpressure_left: got %0d pending, required 0", exp_q.size());
        else n_pass++;
    endtask

    task automatic test_dropped_snap();
        int d0 = done_cnt;
        int p0 = drop_cnt;
        reg_bus = BUS_A; out_ready = 1'b1; snap = 1'b1;
        push_snapshot(BUS_A);
        tick();
        snap = 1'b0;
        tick();
        tick();                       // now showing idx 2
        reg_bus = BUS_B;
        snap = 1'b1;
        tick();
        snap = 1'b0;
        @(negedge clk);
        n_checks++;
        if (snap_drop !== 1'b1 || out_idx !== 2'd3 || out_data !== 16'shFFFF)
            $display("FAIL drop_pulse: got drop=%0d idx=%0d data=%h, required drop=1 idx=3 data=ffff",
                     snap_drop, out_idx, out_data);
        else n_pass++;
        tick();
        @(negedge clk);
        n_checks++;
        if (snap_drop !== 1'b0 || done !== 1'b1 || out_valid !== 1'b0)
            $display("FAIL drop_after: got drop=%0d done=%0d valid=%0d, required drop=0 done=1 valid=0",
                     snap_drop, done, out_valid);
        else n_pass++;
        tick();
        tick();
        n_checks++;
        if (done_cnt != d0 + 1 || drop_cnt != p0 + 1 || exp_q.size() != 0)
            $display("FAIL drop_counts: got done=%0d drop=%0d left=%0d, required done=1 drop=1 left=0",
                     done_cnt - d0, drop_cnt - p0, exp_q.size());
        else n_pass++;
    endtask

    task automatic test_back_to_back();
        int  d0 = done_cnt;
        int  p0 = drop_cnt;
        bit  busy_ok = 1;
        bit  seen = 0;
        reg_bus = BUS_A; out_ready = 1'b1; snap = 1'b1;
        push_snapshot(BUS_A);
        tick();
        snap = 1'b0;
        tick(); tick(); tick();       // now showing final element
        snap = 1'b1;
        reg_bus = BUS_B;
        push_snapshot(BUS_B);
        tick();
        snap = 1'b0;
        @(negedge clk);
        n_checks++;
        if (out_valid !== 1'b1 || out_idx !== 2'd0 || out_data !== 16'sh0011 || done !== 1'b1 || snap_drop !== 1'b0)
            $display("FAIL b2b_restart: got valid=%0d idx=%0d data=%h done=%0d drop=%0d, required valid=1 idx=0 data=0011 done=1 drop=0",
                     out_valid, out_idx, out_data, done, snap_drop);
        else n_pass++;
        tick();
        for (int c = 0; c < 20 && !seen; c++) begin
            @(negedge clk);
            if (done) seen = 1;
            else begin
                if (busy !== 1'b1) busy_ok = 0;
                tick();
            end
        end
        n_checks++;
        if (!seen || !busy_ok)
            $display("FAIL b2b_busy: got done_seen=%0d busy_held=%0d, required 1 and 1", seen, busy_ok);
        else n_pass++;
        tick();
        tick();
        n_checks++;
        if (done_cnt != d0 + 2 || drop_cnt != p0 || exp_q.size() != 0)
            $display("FAIL b2b_counts: got done=%0d drop=%0d left=%0d, required done=2 drop=0 left=0",
                     done_cnt - d0, drop_cnt - p0, exp_q.size());
        else n_pass++;
    endtask

    task automatic test_reset_mid();
        int d0;
        int p0;
        reg_bus = BUS_A; out_ready = 1'b1; snap = 1'b1;
        push_snapshot(BUS_A);
        tick();
        snap = 1'b0;
        tick(); tick();               // now showing idx 2
        d0 = done_cnt;
        p0 = drop_cnt;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        exp_q.delete();               // partial snapshot is discarded
        @(negedge clk);
        n_checks++;
        if (out_valid !== 1'b0 || busy !== 1'b0 || done !== 1'b0 || snap_drop !== 1'b0)
            $display("FAIL rstmid_state: got valid=%0d busy=%0d done=%0d drop=%0d, required all 0",
                     out_valid, busy, done, snap_drop);
        else n_pass++;
        tick();
        n_checks++;
        if (done_cnt != d0 || drop_cnt != p0)
            $display("FAIL rstmid_pulses: got done=%0d drop=%0d, required 0 and 0",
                     done_cnt - d0, drop_cnt - p0);
        else n_pass++;
        reg_bus = BUS_C; snap = 1'b1;
        push_snapshot(BUS_C);
        tick();
        snap = 1'b0;
        @(negedge clk);
        n_checks++;
        if (out_valid !== 1'b1 || out_idx !== 2'd0 || out_data !== 16'sh5A5A)
            $display("FAIL rstmid_restart: got valid=%0d idx=%0d data=%h, required valid=1 idx=0 data=5a5a",
                     out_valid, out_idx, out_data);
        else n_pass++;
        tick();
        wait_done("rstmid");
        n_checks++;
        if (done_cnt != d0 + 1 || exp_q.size() != 0)
            $display("FAIL rstmid_counts: got done=%0d left=%0d, required done=1 left=0",
                     done_cnt - d0, exp_q.size());
        else n_pass++;
    endtask

    initial begin
        rst = 1'b1; snap = 1'b0; out_ready = 1'b0; reg_bus = '0;
        test_reset();
        test_basic();
        test_backpressure();
        test_dropped_snap();
        test_back_to_back();
        test_reset_mid();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got no completion by 200000, required completion");
        $fatal(1, "watchdog expired");
    end

endmodule
